// File: rtl/usram_fetch.sv
`default_nettype none
// usram_fetch: streams word_count 64-bit usram words from base_addr onto a valid/ready stream.
// Optional feature macro: USRAM_FETCH_PERF_EN adds the stall_cycles backpressure counter port.
module usram_fetch #(
  parameter int ADDR_W     = 16,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_pulse,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              usram_rd_en,
  output logic [ADDR_W-1:0] usram_rd_addr,
  input  logic [63:0]       usram_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [63:0]       m_data,
  output logic              m_last
`ifdef USRAM_FETCH_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  localparam int IW = $clog2(FIFO_DEPTH);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [1:0]        state;
  logic [ADDR_W-1:0] rd_ptr;
  logic [LEN_W-1:0]  issue_cnt;
  logic [LEN_W-1:0]  accept_cnt;
  logic              inflight;

  logic [63:0]       mem [FIFO_DEPTH];
  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     rd_idx;
  logic [CW-1:0]     count;

  logic              start_ok;
  logic              push;
  logic              pop;
  logic              credit_ok;
  logic              issue;
  logic              accept_zero_next;
  logic [CW-1:0]     level;

  assign start_ok  = (state == IDLE) && start_pulse;
  assign push      = inflight;
  assign pop       = m_valid && m_ready;
  // Credit counts the read already in flight, so the FIFO can never overflow.
  assign level     = count + CW'(inflight);
  assign credit_ok = level < DEPTH_C;
  assign issue     = (state == FETCH) && credit_ok;
  // Look ahead one cycle so done follows the final transfer directly.
  assign accept_zero_next = (accept_cnt == '0) || (pop && (accept_cnt == LEN_W'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      issue_cnt <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      case (state)
        IDLE: begin
          if (start_pulse) begin
            if (word_count == '0) begin
              state <= FIN;
            end else begin
              rd_ptr    <= base_addr;
              issue_cnt <= word_count;
              state     <= FETCH;
            end
          end
        end
        FETCH: begin
          if (issue) begin
            rd_ptr    <= rd_ptr + ADDR_W'(1);
            issue_cnt <= issue_cnt - LEN_W'(1);
            if (issue_cnt == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (accept_zero_next) state <= FIN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      accept_cnt <= '0;
    end else if (start_ok && (word_count != '0)) begin
      accept_cnt <= word_count;
    end else if (pop) begin
      accept_cnt <= accept_cnt - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= usram_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + IW'(1);
      if (pop)  rd_idx <= rd_idx + IW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign busy          = (state == FETCH) || (state == DRAIN);
  assign done          = (state == FIN);
  assign usram_rd_en   = issue;
  assign usram_rd_addr = rd_ptr;
  assign m_valid       = (count != '0);
  assign m_data        = m_valid ? mem[rd_idx] : 64'd0;
  assign m_last        = m_valid && (accept_cnt == LEN_W'(1));

`ifdef USRAM_FETCH_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if (busy && m_valid && !m_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`endif

endmodule
`default_nettype wire
